// File: rtl/imem_loadable.sv
// Loadable instruction memory: boot-load port writes words, then RUN serves byte-addressed fetches.
// Optional IMEM_CLEAR_EN: reset first sweeps NOP_WORD through every word before BOOT.
module imem_loadable #(
  parameter int                 ADDR_W   = 7,
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              boot_done,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic [31:0]       fetch_addr,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              inst_err
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef IMEM_CLEAR_EN
  typedef enum logic [1:0] {ST_CLEAR = 2'd0, ST_BOOT = 2'd1, ST_RUN = 2'd2} state_t;
  localparam state_t RST_STATE = ST_CLEAR;
`else
  typedef enum logic [1:0] {ST_BOOT = 2'd1, ST_RUN = 2'd2} state_t;
  localparam state_t RST_STATE = ST_BOOT;
`endif

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [ADDR_W-1:0]   fetch_idx;
  logic                fetch_misaligned;
  logic                fetch_oor;
  logic                fetch_err;
  logic                fetch_acc;

`ifdef IMEM_CLEAR_EN
  logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
`endif

  assign ld_ready    = (state_reg == ST_BOOT);
  assign fetch_ready = (state_reg == ST_RUN);
  assign boot_done   = (state_reg == ST_RUN);

  // Fetch address decode: word index plus alignment / range checks.
  assign fetch_idx        = fetch_addr[ADDR_W+1:2];
  assign fetch_misaligned = (fetch_addr[1:0] != 2'b00);
  generate
    if (ADDR_W + 2 < 32) begin : g_oor
      assign fetch_oor = |fetch_addr[31:ADDR_W+2];
    end else begin : g_no_oor
      assign fetch_oor = 1'b0;
    end
  endgenerate
  assign fetch_err = fetch_misaligned | fetch_oor;
  assign fetch_acc = fetch_req & fetch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RST_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef IMEM_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_reg <= '0;
    end else begin
      clr_cnt_reg <= clr_cnt_next;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    mem_we     = 1'b0;
    mem_waddr  = ld_addr;
    mem_wdata  = ld_data;
`ifdef IMEM_CLEAR_EN
    clr_cnt_next = clr_cnt_reg;
`endif
    case (state_reg)
`ifdef IMEM_CLEAR_EN
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_cnt_reg;
        mem_wdata    = NOP_WORD;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == {ADDR_W{1'b1}}) begin
          state_next = ST_BOOT;
        end
      end
`endif
      ST_BOOT: begin
        // ld_last only counts when it rides on an accepted beat.
        if (ld_valid) begin
          mem_we = 1'b1;
          if (ld_last) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = RST_STATE;
      end
    endcase
  end

  // Memory array has no reset; a write in the reset cycle is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid <= 1'b0;
      inst_err   <= 1'b0;
      inst       <= NOP_WORD;
    end else begin
      inst_valid <= fetch_acc;
      inst_err   <= fetch_acc & fetch_err;
      if (fetch_acc) begin
        inst <= fetch_err ? NOP_WORD : mem[fetch_idx];
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: expected fetch responses are queued when driven and popped on inst_valid.
module tb_imem_loadable;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              boot_done;
  logic              fetch_req;
  logic              fetch_ready;
  logic [31:0]       fetch_addr;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic              inst_err;

  imem_loadable #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD('0)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .boot_done(boot_done),
    .fetch_req(fetch_req), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
    .inst_valid(inst_valid), .inst(inst), .inst_err(inst_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] model_mem [0:127];
  int          errors = 0;
  int          checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid   = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    ld_last    = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
  endtask

  // Reference response: 128 words, byte addressed, word aligned.
  task automatic push_fetch(input logic [31:0] a);
    resp_t r;
    r.err  = (a[1:0] != 2'b00) || (a[31:9] != 23'd0);
    r.word = r.err ? 32'h0 : model_mem[a[8:2]];
    exp_q.push_back(r);
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (!ld_ready && n < 300) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 128) begin
      errors++;
      $display("FAIL %s: ld_ready low for %0d cycles, expected 128", name, n);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_err !== 1'b0 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b inst=%h err=%b boot_done=%b, expected 0/00000000/0/0",
               inst_valid, inst, inst_err, boot_done);
    end
`ifdef IMEM_CLEAR_EN
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ld_ready: got %b expected 0 (clearing)", ld_ready);
    end
    rst = 1'b0;
    wait_clear("reset_clear_len");
    for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
`else
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ld_ready: got %b expected 1", ld_ready);
    end
    rst = 1'b0;
`endif
  endtask

  task automatic test_load_first_fetch();
    logic [6:0]  la [3];
    logic [31:0] ld [3];
    resp_t       r;
    la[0] = 7'd127; ld[0] = 32'hdeadbeef;
    la[1] = 7'd0;   ld[1] = 32'h8c150000;
    la[2] = 7'd1;   ld[2] = 32'h20100004;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_addr  = la[i];
      ld_data  = ld[i];
      ld_last  = (i == 2);
      checks++;
      if (ld_ready !== 1'b1 || boot_done !== 1'b0) begin
        errors++;
        $display("FAIL load_beat%0d: ld_ready=%b boot_done=%b, expected 1/0", i, ld_ready, boot_done);
      end
      model_mem[la[i]] = ld[i];
      tick();
    end
    idle();
    checks++;
    if (boot_done !== 1'b1 || ld_ready !== 1'b0 || fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL boot_done: boot_done=%b ld_ready=%b fetch_ready=%b, expected 1/0/1",
               boot_done, ld_ready, fetch_ready);
    end
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    push_fetch(fetch_addr);
    tick();
    idle();
    r = exp_q.pop_front();
    checks++;
    if (inst_valid !== 1'b1 || inst !== r.word || inst_err !== r.err) begin
      errors++;
      $display("FAIL first_fetch: valid=%b inst=%h err=%b, expected 1/%h/%b",
               inst_valid, inst, inst_err, r.word, r.err);
    end
  endtask

  // Includes a load attempt in RUN, which must not change memory.
  task automatic test_back_to_back();
    logic [31:0] addrs [7];
    resp_t       r;
    logic [31:0] last_word;
    addrs[0] = 32'h0;   addrs[1] = 32'h4;        addrs[2] = 32'h0;
    addrs[3] = 32'h6;   addrs[4] = 32'h200;      addrs[5] = 32'h1fc;
    addrs[6] = 32'hfffffffc;
    last_word = 32'h0;
    for (int i = 0; i < 7; i++) begin
      ld_valid   = 1'b1;
      ld_addr    = 7'd0;
      ld_data    = 32'hffffffff;
      ld_last    = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = addrs[i];
      push_fetch(fetch_addr);
      tick();
      r = exp_q.pop_front();
      last_word = r.word;
      checks++;
      if (inst_valid !== 1'b1 || inst !== r.word || inst_err !== r.err) begin
        errors++;
        $display("FAIL b2b_fetch addr=%h: valid=%b inst=%h err=%b, expected 1/%h/%b",
                 addrs[i], inst_valid, inst, inst_err, r.word, r.err);
      end
    end
    idle();
    tick();
    checks++;
    if (inst_valid !== 1'b0 || inst_err !== 1'b0 || inst !== last_word) begin
      errors++;
      $display("FAIL idle_hold: valid=%b err=%b inst=%h, expected 0/0/%h",
               inst_valid, inst_err, inst, last_word);
    end
  endtask

  task automatic test_reset_mid_run_and_boot_fetch();
    resp_t r;
    int    n;
    // Fetch in flight during the reset edge must be dropped.
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (inst_valid !== 1'b0 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: valid=%b boot_done=%b, expected 0/0", inst_valid, boot_done);
    end
`ifdef IMEM_CLEAR_EN
    wait_clear("mid_run_clear_len");
    for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
`else
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run_ld_ready: got %b expected 1", ld_ready);
    end
`endif
    // ld_last without ld_valid must not finish boot.
    ld_last   = 1'b1;
    fetch_req = 1'b1;
    tick();
    checks++;
    if (boot_done !== 1'b0 || inst_valid !== 1'b0 || fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL lone_ld_last: boot_done=%b valid=%b fetch_ready=%b, expected 0/0/0",
               boot_done, inst_valid, fetch_ready);
    end
    // Final beat with fetch held: fetch accepted only from the first RUN cycle.
    ld_valid = 1'b1;
    ld_addr  = 7'd1;
    ld_data  = 32'h20100004;
    model_mem[1] = 32'h20100004;
    n = 0;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || boot_done !== 1'b1 || fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL boot_fetch_hold: valid=%b boot_done=%b fetch_ready=%b, expected 0/1/1",
               inst_valid, boot_done, fetch_ready);
    end
    push_fetch(fetch_addr);
    tick();
    idle();
    r = exp_q.pop_front();
    checks++;
    if (inst_valid !== 1'b1 || inst !== r.word || inst_err !== r.err) begin
      errors++;
      $display("FAIL post_reset_fetch: valid=%b inst=%h err=%b, expected 1/%h/%b",
               inst_valid, inst, inst_err, r.word, r.err);
    end
    while (n < 1) n++;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_load_first_fetch();
    test_back_to_back();
    test_reset_mid_run_and_boot_fetch();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
